// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder
//
// Frame source for the 2-D convolution engine. One IMG_WIDTH x IMG_HEIGHT
// 8-bit frame is held in an internal buffer that is loaded through a simple
// write port while idle. On frame_go the block pulses start_signal, leaves
// one dead cycle, streams the frame in raster order on pixel_out/pixel_valid,
// then waits for the engine's done_signal and reports frame_done or
// timeout_err.
//
// Optional feature macro: FEEDER_GAP_EN
//   defined   : gap_cycles idle cycles are inserted after every row except
//               the last (GAP state present).
//   undefined : gap_cycles is ignored; pixels stream every cycle.
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   rst          in   synchronous active-high reset (buffer contents kept)
//   wr_en        in   buffer write strobe (honoured only in IDLE)
//   wr_addr      in   raster address y*IMG_WIDTH+x
//   wr_data      in   pixel to store
//   frame_go     in   start request, sampled only in IDLE
//   gap_cycles   in   idle cycles after each row (FEEDER_GAP_EN only)
//   done_signal  in   engine completion pulse, sampled only in WAIT_DONE
//   start_signal out  one-cycle start pulse to the engine
//   pixel_out    out  streamed pixel, holds its value between pixels
//   pixel_valid  out  pixel_out qualifier
//   busy         out  high in every state except IDLE
//   frame_done   out  one-cycle pulse after done_signal is received
//   timeout_err  out  sticky; cleared by the next accepted frame_go or rst
module pixel_stream_feeder #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int TIMEOUT    = 64,
  parameter int GAP_W      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
  input  logic [7:0]                            wr_data,
  input  logic                                  frame_go,
  input  logic [GAP_W-1:0]                      gap_cycles,
  input  logic                                  done_signal,
  output logic                                  start_signal,
  output logic [7:0]                            pixel_out,
  output logic                                  pixel_valid,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  timeout_err
);

  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = (IMG_WIDTH > 1)  ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int TW    = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LEAD,
    STREAM,
    GAP,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [XW-1:0]   x;          // column of the pixel currently presented
  logic [YW-1:0]   y;          // row of the pixel currently presented
  logic [AW-1:0]   rd_addr;    // next buffer address to read
  logic [TW-1:0]   wait_cnt;
  logic [7:0]      mem [DEPTH];

  logic            row_end;
  logic            frame_end;
  logic            gap_go;
  logic            issue_rd;
  logic            wr_ok;

`ifdef FEEDER_GAP_EN
  logic [GAP_W-1:0] gap_cnt;
  assign gap_go = (gap_cycles != '0);
`else
  logic unused_gap;
  assign unused_gap = ^gap_cycles;
  assign gap_go     = 1'b0;
`endif

  assign row_end   = (x == X_LAST);
  assign frame_end = row_end && (y == Y_LAST);

  // The buffer is frozen outside IDLE so a frame is never torn mid-stream.
  assign wr_ok = (state == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A buffer read is issued one cycle ahead of the pixel it produces; the
  // read register itself is pixel_out, so pixel_valid follows issue_rd.
  always_comb begin
    issue_rd = 1'b0;
    case (state)
      LEAD:    issue_rd = 1'b1;
      STREAM:  issue_rd = !frame_end && !(row_end && gap_go);
`ifdef FEEDER_GAP_EN
      GAP:     issue_rd = (gap_cnt == '0);
`endif
      default: issue_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_signal <= 1'b0;
      pixel_out    <= 8'h00;
      pixel_valid  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      x            <= '0;
      y            <= '0;
      rd_addr      <= '0;
      wait_cnt     <= '0;
`ifdef FEEDER_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      start_signal <= 1'b0;
      frame_done   <= 1'b0;
      pixel_valid  <= issue_rd;
      if (issue_rd) begin
        pixel_out <= mem[rd_addr];
        rd_addr   <= rd_addr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_go) begin
            state        <= START;
            start_signal <= 1'b1;
            busy         <= 1'b1;
            timeout_err  <= 1'b0;
          end
        end

        START: begin
          x       <= '0;
          y       <= '0;
          rd_addr <= '0;
          state   <= LEAD;
        end

        LEAD: begin
          state <= STREAM;
        end

        STREAM: begin
          if (frame_end) begin
            state    <= WAIT_DONE;
            wait_cnt <= '0;
          end else begin
            if (row_end) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
`ifdef FEEDER_GAP_EN
            if (row_end && gap_go) begin
              state   <= GAP;
              gap_cnt <= gap_cycles - 1'b1;
            end
`endif
          end
        end

`ifdef FEEDER_GAP_EN
        GAP: begin
          if (gap_cnt == '0) begin
            state <= STREAM;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`endif

        WAIT_DONE: begin
          // done_signal takes priority over a timeout on the same cycle.
          if (done_signal) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Testbench for pixel_stream_feeder. Stimulus pushes expected pixels (value
// and cycle), start pulses, frame_done pulses and timeout rises into queues;
// an independent monitor pops and compares whenever the DUT presents them.
module tb_pixel_stream_feeder;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       frame_go = 1'b0;
  logic [3:0] gap_cycles = '0;
  logic       done_signal = 1'b0;
  logic       start_signal;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  pixel_stream_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_go    (frame_go),
    .gap_cycles  (gap_cycles),
    .done_signal (done_signal),
    .start_signal(start_signal),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } pix_exp_t;

  pix_exp_t   pix_q[$];
  int         start_q[$];
  int         done_q[$];
  int         to_q[$];
  logic [7:0] model_mem [NPIX];

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] last_exp = 8'h00;
  logic       prev_to = 1'b0;
  logic       rst_edge;
  pix_exp_t   mon_e;
  int         mon_c;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    rst_edge = rst;
    cyc = cyc + 1;
    #1;
    if (rst_edge) begin
      last_exp = 8'h00;
      prev_to  = 1'b0;
    end else begin
      if (pixel_valid) begin
        n_tests++;
        if (pix_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_unexpected: got %0h at cycle %0d, required no pixel", pixel_out, cyc);
        end else begin
          mon_e = pix_q.pop_front();
          last_exp = mon_e.val;
          if (pixel_out !== mon_e.val || cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL pixel: got %0h at cycle %0d, required %0h at cycle %0d",
                     pixel_out, cyc, mon_e.val, mon_e.cyc);
          end
        end
      end else if (busy) begin
        check("pixel_hold", 32'(pixel_out), 32'(last_exp));
      end

      if (start_signal) begin
        n_tests++;
        if (start_q.size() == 0) begin
          n_fail++;
          $display("FAIL start_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_c = start_q.pop_front();
          if (mon_c != cyc) begin
            n_fail++;
            $display("FAIL start_cycle: got %0d required %0d", cyc, mon_c);
          end
        end
      end

      if (frame_done) begin
        n_tests++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_done_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_c = done_q.pop_front();
          if (mon_c != cyc) begin
            n_fail++;
            $display("FAIL frame_done_cycle: got %0d required %0d", cyc, mon_c);
          end
        end
      end

      if (timeout_err && !prev_to) begin
        n_tests++;
        if (to_q.size() == 0) begin
          n_fail++;
          $display("FAIL timeout_unexpected: got rise at cycle %0d, required none", cyc);
        end else begin
          mon_c = to_q.pop_front();
          if (mon_c != cyc) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d required %0d", cyc, mon_c);
          end
        end
      end
      prev_to = timeout_err;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulses frame_go and queues the expected start pulse and the first npix
  // pixels. t_go is the cycle frame_go is sampled; t_last the last-pixel cycle.
  task automatic start_frame(input int gap, input int npix, output int t_go, output int t_last);
    int       geff;
    pix_exp_t e;
    @(negedge clk);
    gap_cycles = 4'(gap);
    frame_go   = 1'b1;
    t_go       = cyc;
`ifdef FEEDER_GAP_EN
    geff = gap;
`else
    geff = 0;
`endif
    start_q.push_back(t_go + 1);
    for (int k = 0; k < npix; k++) begin
      e.val = model_mem[k];
      e.cyc = t_go + 3 + k + (k / W) * geff;
      pix_q.push_back(e);
    end
    t_last = t_go + 2 + NPIX + (H - 1) * geff;
    @(negedge clk);
    frame_go = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start_signal"}, 32'(start_signal), 0);
    check({tag, "_pixel_out"},    32'(pixel_out),    0);
    check({tag, "_pixel_valid"},  32'(pixel_valid),  0);
    check({tag, "_busy"},         32'(busy),         0);
    check({tag, "_frame_done"},   32'(frame_done),   0);
    check({tag, "_timeout_err"},  32'(timeout_err),  0);
  endtask

  initial begin
    int t;
    int l;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Ramp frame: buffer[a] = a[7:0].
    for (int a = 0; a < NPIX; a++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(a);
      wr_data = 8'(a);
      model_mem[a] = 8'(a);
      @(negedge clk);
    end
    wr_en = 1'b0;
    $display("[TB] loaded ramp frame, %0d pixels", NPIX);

    // Frame 1: continuous, write lockout and ignored frame_go while streaming.
    start_frame(0, NPIX, t, l);
    check("f1_busy_start", 32'(busy), 1);
    wait_until(t + 53);
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    wait_until(t + 63);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    wait_until(l + 10);
    done_signal = 1'b1;
    done_q.push_back(l + 11);
    @(negedge clk);
    done_signal = 1'b0;
    check("f1_busy_after_done", 32'(busy), 0);
    check("f1_timeout_err", 32'(timeout_err), 0);
    $display("[TB] frame 1 continuous: go at %0d, last pixel at %0d, done at %0d", t, l, l + 11);

    // Frame 2: gap_cycles=3 (active only with the gap feature), buffer[5]
    // still holds its original value, earliest possible done_signal.
    repeat (2) @(negedge clk);
    start_frame(3, NPIX, t, l);
    wait_until(l + 1);
    done_signal = 1'b1;
    done_q.push_back(l + 2);
    @(negedge clk);
    done_signal = 1'b0;
    check("f2_busy_after_done", 32'(busy), 0);
    gap_cycles = 4'd0;
    $display("[TB] frame 2 gap=3: go at %0d, last pixel at %0d, done at %0d", t, l, l + 2);

    // IDLE write is honoured.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hA5;
    model_mem[5] = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;

    // Frame 3: no done_signal, timeout; frame_go in WAIT_DONE is ignored.
    start_frame(0, NPIX, t, l);
    to_q.push_back(l + 65);
    wait_until(l + 30);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    wait_until(l + 65);
    check("f3_timeout_err", 32'(timeout_err), 1);
    check("f3_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("f3_err_sticky", 32'(timeout_err), 1);
    $display("[TB] frame 3 timeout: go at %0d, last pixel at %0d, timeout at %0d", t, l, l + 65);

    // Frame 4: timeout_err clears on accept; reset at pixel 100.
    start_frame(0, 101, t, l);
    check("f4_err_cleared", 32'(timeout_err), 0);
    wait_until(t + 103);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    $display("[TB] frame 4 reset at pixel 100: go at %0d, reset sampled at %0d", t, t + 103);

    // Frame 5: full frame after reset, done_signal on the timeout cycle.
    repeat (3) @(negedge clk);
    start_frame(0, NPIX, t, l);
    wait_until(l + 64);
    done_signal = 1'b1;
    done_q.push_back(l + 65);
    @(negedge clk);
    done_signal = 1'b0;
    check("f5_timeout_err", 32'(timeout_err), 0);
    check("f5_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("f5_timeout_err_late", 32'(timeout_err), 0);
    $display("[TB] frame 5 done on timeout cycle: go at %0d, last pixel at %0d", t, l);

    repeat (3) @(negedge clk);
    check("left_pixels", 32'(pix_q.size()), 0);
    check("left_starts", 32'(start_q.size()), 0);
    check("left_dones", 32'(done_q.size()), 0);
    check("left_timeouts", 32'(to_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
